// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile's single write port between two writeback requesters.
// Each requester has a one-entry buffer, arbitration is round-robin, and a zero-fill runs after every reset.
module regfile_wb_arbiter #(
  parameter int AW   = 4,
  parameter int DW   = 16,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_data,
  output logic            we,
  output logic [AW-1:0]   wa1,
  output logic [DW-1:0]   wd1,
  output logic            init_done,
  output logic [NREG-1:0] pend_mask
);

  typedef enum logic {INIT, RUN} state_t;
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg;
  logic          a_full_reg, b_full_reg;
  logic [AW-1:0] a_addr_reg, b_addr_reg;
  logic [DW-1:0] a_data_reg, b_data_reg;
  logic          ptr_b_reg;
  logic          we_reg, we_next;
  logic [AW-1:0] wa1_reg, wa1_next;
  logic [DW-1:0] wd1_reg, wd1_next;
  logic          grant_a, grant_b;
  logic          a_accept, b_accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == INIT && cnt_reg == LAST) begin
      state_next = RUN;
    end
  end

  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    we_next  = 1'b0;
    wa1_next = wa1_reg;
    wd1_next = wd1_reg;
    case (state_reg)
      INIT: begin
        we_next  = 1'b1;
        wa1_next = cnt_reg;
        wd1_next = '0;
      end
      RUN: begin
        // ptr_b_reg low means A wins when both buffers are full
        grant_a = a_full_reg && (!b_full_reg || !ptr_b_reg);
        grant_b = b_full_reg && (!a_full_reg || ptr_b_reg);
        a_ready = !a_full_reg || grant_a;
        b_ready = !b_full_reg || grant_b;
        if (grant_a) begin
          we_next  = 1'b1;
          wa1_next = a_addr_reg;
          wd1_next = a_data_reg;
        end else if (grant_b) begin
          we_next  = 1'b1;
          wa1_next = b_addr_reg;
          wd1_next = b_data_reg;
        end
      end
    endcase
  end

  assign a_accept = a_valid && a_ready;
  assign b_accept = b_valid && b_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg    <= '0;
      a_full_reg <= 1'b0;
      b_full_reg <= 1'b0;
      a_addr_reg <= '0;
      b_addr_reg <= '0;
      a_data_reg <= '0;
      b_data_reg <= '0;
      ptr_b_reg  <= 1'b0;
      we_reg     <= 1'b0;
      wa1_reg    <= '0;
      wd1_reg    <= '0;
    end else begin
      we_reg  <= we_next;
      wa1_reg <= wa1_next;
      wd1_reg <= wd1_next;
      if (state_reg == INIT) begin
        cnt_reg <= cnt_reg + AW'(1);
      end
      if (a_full_reg && b_full_reg) begin
        ptr_b_reg <= !ptr_b_reg;
      end
      // A new entry overrides the drain when the buffer is granted on the same edge
      if (a_accept) begin
        a_full_reg <= 1'b1;
        a_addr_reg <= a_addr;
        a_data_reg <= a_data;
      end else if (grant_a) begin
        a_full_reg <= 1'b0;
      end
      if (b_accept) begin
        b_full_reg <= 1'b1;
        b_addr_reg <= b_addr;
        b_data_reg <= b_data;
      end else if (grant_b) begin
        b_full_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pend
      assign pend_mask[gi] = (a_full_reg && a_addr_reg == AW'(gi)) ||
                             (b_full_reg && b_addr_reg == AW'(gi)) ||
                             (we_reg && wa1_reg == AW'(gi));
    end
  endgenerate

  assign we        = we_reg;
  assign wa1       = wa1_reg;
  assign wd1       = wd1_reg;
  assign init_done = (state_reg == RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model and a bench-side register file.
module tb_regfile_wb_arbiter;
  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int NREG = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic            a_ready, b_ready;
  logic [AW-1:0]   a_addr = '0, b_addr = '0;
  logic [DW-1:0]   a_data = '0, b_data = '0;
  logic            we, init_done;
  logic [AW-1:0]   wa1;
  logic [DW-1:0]   wd1;
  logic [NREG-1:0] pend_mask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we(we), .wa1(wa1), .wd1(wd1), .init_done(init_done), .pend_mask(pend_mask)
  );

  // Register file fed by the DUT write port, plus a log of every issued write
  logic [DW-1:0]    rf [NREG];
  logic [AW+DW-1:0] wlog [$];
  always @(posedge clk) begin
    if (we === 1'b1) begin
      rf[wa1] <= wd1;
      wlog.push_back({wa1, wd1});
    end
  end

  // Reference model: pending writes as queues of depth <= 1, fill as a write count
  logic [AW+DW-1:0] qa [$];
  logic [AW+DW-1:0] qb [$];
  bit               m_favour_a = 1'b1;
  int               m_fill = 0;
  logic             m_we = 1'b0;
  logic [AW-1:0]    m_wa = '0;
  logic [DW-1:0]    m_wd = '0;
  logic [DW-1:0]    mem [NREG];

  function automatic int m_winner();
    if (m_fill < NREG) return 0;
    if (qa.size() != 0 && qb.size() != 0) return m_favour_a ? 1 : 2;
    if (qa.size() != 0) return 1;
    if (qb.size() != 0) return 2;
    return 0;
  endfunction

  function automatic bit m_ready_a();
    return (m_fill == NREG) && (qa.size() == 0 || m_winner() == 1);
  endfunction

  function automatic bit m_ready_b();
    return (m_fill == NREG) && (qb.size() == 0 || m_winner() == 2);
  endfunction

  function automatic logic [NREG-1:0] m_pend();
    logic [NREG-1:0] p;
    p = '0;
    foreach (qa[k]) p[qa[k][AW+DW-1:DW]] = 1'b1;
    foreach (qb[k]) p[qb[k][AW+DW-1:DW]] = 1'b1;
    if (m_we) p[m_wa] = 1'b1;
    return p;
  endfunction

  always @(posedge clk) begin : model
    int win;
    bit ra, rb, both;
    logic [AW+DW-1:0] e;
    if (m_we) mem[m_wa] = m_wd;
    if (!rst) begin
      qa.delete();
      qb.delete();
      m_favour_a = 1'b1;
      m_fill = 0;
      m_we = 1'b0;
      m_wa = '0;
      m_wd = '0;
    end else if (m_fill < NREG) begin
      m_we = 1'b1;
      m_wa = AW'(m_fill);
      m_wd = '0;
      m_fill++;
    end else begin
      win  = m_winner();
      ra   = m_ready_a();
      rb   = m_ready_b();
      both = (qa.size() != 0 && qb.size() != 0);
      if (win == 1) begin
        e = qa.pop_front();
        m_we = 1'b1; m_wa = e[AW+DW-1:DW]; m_wd = e[DW-1:0];
      end else if (win == 2) begin
        e = qb.pop_front();
        m_we = 1'b1; m_wa = e[AW+DW-1:DW]; m_wd = e[DW-1:0];
      end else begin
        m_we = 1'b0;
      end
      if (both) m_favour_a = !m_favour_a;
      if (a_valid && ra) qa.push_back({a_addr, a_data});
      if (b_valid && rb) qb.push_back({b_addr, b_data});
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({we, init_done, a_ready, b_ready} !== 4'b0000 || pend_mask !== '0) begin
      n_errors++;
      $display("FAIL reset_state got we=%b done=%b ar=%b br=%b pend=%h want 0 0 0 0 0000",
               we, init_done, a_ready, b_ready, pend_mask);
    end
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      n_checks++;
      if (we !== 1'b1 || wa1 !== AW'(i) || wd1 !== '0) begin
        n_errors++;
        $display("FAIL fill_write i=%0d got we=%b wa1=%h wd1=%h want 1 %h 0000", i, we, wa1, wd1, i[AW-1:0]);
      end
      n_checks++;
      if (init_done !== (i == NREG - 1) || a_ready !== (i == NREG - 1) || b_ready !== (i == NREG - 1)) begin
        n_errors++;
        $display("FAIL fill_ready i=%0d got done=%b ar=%b br=%b want %b", i, init_done, a_ready, b_ready, i == NREG - 1);
      end
      n_checks++;
      if (pend_mask !== (NREG'(1) << i)) begin
        n_errors++;
        $display("FAIL fill_pend i=%0d got %h want %h", i, pend_mask, NREG'(1) << i);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NREG; i++) begin
      n_checks++;
      if (rf[i] !== '0) begin
        n_errors++;
        $display("FAIL fill_rf reg=%0d got %h want 0000", i, rf[i]);
      end
    end
  endtask

  task automatic test_single_write();
    a_valid = 1'b1; a_addr = 4'h3; a_data = 16'hAAAA;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL single_ready got %b want 1", a_ready);
    end
    @(negedge clk);
    a_valid = 1'b0;
    n_checks++;
    if (we !== 1'b0 || pend_mask !== 16'h0008) begin
      n_errors++;
      $display("FAIL single_buffered got we=%b pend=%h want 0 0008", we, pend_mask);
    end
    @(negedge clk);
    n_checks++;
    if (we !== 1'b1 || wa1 !== 4'h3 || wd1 !== 16'hAAAA || pend_mask !== 16'h0008) begin
      n_errors++;
      $display("FAIL single_issue got we=%b wa1=%h wd1=%h pend=%h want 1 3 aaaa 0008", we, wa1, wd1, pend_mask);
    end
    @(negedge clk);
    n_checks++;
    if (pend_mask !== '0 || rf[3] !== 16'hAAAA) begin
      n_errors++;
      $display("FAIL single_commit got pend=%h rf3=%h want 0000 aaaa", pend_mask, rf[3]);
    end
  endtask

  task automatic test_contention();
    logic [AW+DW-1:0] exp_order [6];
    int ia = 0, ib = 0;
    bit acc_a = 1'b0, acc_b = 1'b0;
    exp_order = '{{4'h1, 16'hA001}, {4'h4, 16'hB004}, {4'h2, 16'hA002},
                  {4'h5, 16'hB005}, {4'h3, 16'hA003}, {4'h6, 16'hB006}};
    wlog.delete();
    for (int c = 0; c < 10; c++) begin
      if (acc_a) ia++;
      if (acc_b) ib++;
      a_valid = (ia < 3); a_addr = AW'(1 + ia); a_data = 16'hA001 + DW'(ia);
      b_valid = (ib < 3); b_addr = AW'(4 + ib); b_data = 16'hB004 + DW'(ib);
      n_checks++;
      if (a_ready !== m_ready_a() || b_ready !== m_ready_b()) begin
        n_errors++;
        $display("FAIL contention_ready cyc=%0d got ar=%b br=%b want %b %b", c, a_ready, b_ready, m_ready_a(), m_ready_b());
      end
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wlog.size() != 6) begin
      n_errors++;
      $display("FAIL contention_count got %0d writes want 6", wlog.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= wlog.size() || wlog[i] !== exp_order[i]) begin
        n_errors++;
        $display("FAIL contention_order idx=%0d got %h want %h", i, (i < wlog.size()) ? wlog[i] : 'x, exp_order[i]);
      end
    end
  endtask

  task automatic test_same_addr();
    if (!m_favour_a) begin
      // a contested pair that B wins returns the pointer to A
      a_valid = 1'b1; a_addr = 4'hE; a_data = 16'h0E0E;
      b_valid = 1'b1; b_addr = 4'hF; b_data = 16'h0F0F;
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    wlog.delete();
    a_valid = 1'b1; a_addr = 4'h5; a_data = 16'hBBBB;
    b_valid = 1'b1; b_addr = 4'h5; b_data = 16'hCCCC;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL race_ready got ar=%b br=%b want 1 1", a_ready, b_ready);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wlog.size() != 2 || wlog[0] !== {4'h5, 16'hBBBB} || wlog[1] !== {4'h5, 16'hCCCC}) begin
      n_errors++;
      $display("FAIL race_order got n=%0d first=%h second=%h want 2 5bbbb 5cccc",
               wlog.size(), (wlog.size() > 0) ? wlog[0] : 'x, (wlog.size() > 1) ? wlog[1] : 'x);
    end
    n_checks++;
    if (rf[5] !== 16'hCCCC) begin
      n_errors++;
      $display("FAIL race_final got %h want cccc", rf[5]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        b_valid = 1'b1; b_addr = AW'(7 + i); b_data = 16'h00D0 + DW'(i);
        n_checks++;
        if (b_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL b2b_ready i=%0d got %b want 1", i, b_ready);
        end
      end else begin
        b_valid = 1'b0;
      end
      if (i >= 2) begin
        n_checks++;
        if (we !== 1'b1 || wa1 !== AW'(7 + i - 2) || wd1 !== 16'h00D0 + DW'(i - 2)) begin
          n_errors++;
          $display("FAIL b2b_write i=%0d got we=%b wa1=%h wd1=%h want 1 %h %h",
                   i, we, wa1, wd1, AW'(7 + i - 2), 16'h00D0 + DW'(i - 2));
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (we !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle got we=%b want 0", we);
    end
  endtask

  task automatic test_mid_reset();
    a_valid = 1'b1; a_addr = 4'h2; a_data = 16'h1234;
    b_valid = 1'b1; b_addr = 4'h9; b_data = 16'h5678;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    n_checks++;
    if (pend_mask !== 16'h0204) begin
      n_errors++;
      $display("FAIL midrst_full got pend=%h want 0204", pend_mask);
    end
    rst = 1'b0;
    wlog.delete();
    @(negedge clk);
    n_checks++;
    if ({we, init_done, a_ready, b_ready} !== 4'b0000 || pend_mask !== '0) begin
      n_errors++;
      $display("FAIL midrst_state got we=%b done=%b ar=%b br=%b pend=%h want 0 0 0 0 0000",
               we, init_done, a_ready, b_ready, pend_mask);
    end
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      n_checks++;
      if (we !== 1'b1 || wa1 !== AW'(i) || wd1 !== '0 || a_ready !== (i == NREG - 1)) begin
        n_errors++;
        $display("FAIL midrst_fill i=%0d got we=%b wa1=%h wd1=%h ar=%b", i, we, wa1, wd1, a_ready);
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wlog.size() != NREG || pend_mask !== '0 || rf[2] !== '0 || rf[9] !== '0) begin
      n_errors++;
      $display("FAIL midrst_dropped got writes=%0d pend=%h rf2=%h rf9=%h want 16 0000 0000 0000",
               wlog.size(), pend_mask, rf[2], rf[9]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      n_checks++;
      if (we !== m_we || wa1 !== m_wa || wd1 !== m_wd) begin
        n_errors++;
        $display("FAIL rand_port cyc=%0d got %b %h %h want %b %h %h", c, we, wa1, wd1, m_we, m_wa, m_wd);
      end
      n_checks++;
      if (a_ready !== m_ready_a() || b_ready !== m_ready_b() || init_done !== (m_fill == NREG)) begin
        n_errors++;
        $display("FAIL rand_ready cyc=%0d got ar=%b br=%b done=%b want %b %b %b",
                 c, a_ready, b_ready, init_done, m_ready_a(), m_ready_b(), m_fill == NREG);
      end
      n_checks++;
      if (pend_mask !== m_pend()) begin
        n_errors++;
        $display("FAIL rand_pend cyc=%0d got %h want %h", c, pend_mask, m_pend());
      end
      rst     = ($urandom_range(0, 149) != 0);
      a_valid = ($urandom_range(0, 2) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      a_addr  = AW'($urandom);
      b_addr  = AW'($urandom);
      a_data  = DW'($urandom);
      b_data  = DW'($urandom);
      @(negedge clk);
    end
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    repeat (24) @(negedge clk);
    for (int i = 0; i < NREG; i++) begin
      n_checks++;
      if (rf[i] !== mem[i]) begin
        n_errors++;
        $display("FAIL rand_rf reg=%0d got %h want %h", i, rf[i], mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_same_addr();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
